// File: rtl/irrigation_actuator_if.sv
// Bus between the irrigation state register (master) and the actuator stage
// (slave): requested mode and tank sensors in, actuator drives and status out.
interface irrigation_actuator_if;
    logic [1:0] state;
    logic [3:0] water_tank_level;
    logic       valve_drip;
    logic       valve_sprinkler;
    logic       valve_fill;
    logic       pump;
    logic       busy;
    logic       fault;
    logic [7:0] cycle_count;

    modport master (
        output state,
        output water_tank_level,
        input  valve_drip,
        input  valve_sprinkler,
        input  valve_fill,
        input  pump,
        input  busy,
        input  fault,
        input  cycle_count
    );

    modport slave (
        input  state,
        input  water_tank_level,
        output valve_drip,
        output valve_sprinkler,
        output valve_fill,
        output pump,
        output busy,
        output fault,
        output cycle_count
    );
endinterface

// File: rtl/irrigation_actuator.sv
// irrigation_actuator: sequences valves and pump for drip / sprinkler / refill
// requests. The valve opens VALVE_LEAD cycles before the pump, the pump runs
// at least MIN_ON cycles and stops PUMP_LAG cycles before the valve closes.
// Dry-run (pumped modes) or a corrupt tank-level code trips a latched fault.
// Optional feature macro: IRRIG_CYCLE_COUNT_EN enables the saturating count of
// completed pumped runs on cycle_count; otherwise cycle_count is tied to zero.
module irrigation_actuator #(
    parameter int unsigned VALVE_LEAD = 4,
    parameter int unsigned PUMP_LAG   = 3,
    parameter int unsigned MIN_ON     = 10
) (
    input logic                  clk,
    input logic                  initialize,
    irrigation_actuator_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        OPEN,
        RUN,
        STOP,
        FAULT
    } fsm_e;

    localparam logic [7:0] LEAD_LOAD = 8'(VALVE_LEAD - 1);
    localparam logic [7:0] LAG_LOAD  = 8'(PUMP_LAG - 1);
    localparam logic [7:0] RUN_LOAD  = 8'(MIN_ON - 1);

    fsm_e       state_q;
    logic [1:0] m_q;
    logic [7:0] timer_q;

    logic valve_drip_q;
    logic valve_sprinkler_q;
    logic valve_fill_q;
    logic pump_q;
    logic busy_q;
    logic fault_q;

    logic level_ok_d;
    logic dry_d;
    logic pumped_d;
    logic trip_d;

    // Accept only thermometer codes from the tank sensors.
    always_comb begin
        level_ok_d = 1'b0;
        case (bus.water_tank_level)
            4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111: level_ok_d = 1'b1;
            default:                                     level_ok_d = 1'b0;
        endcase
    end

    assign dry_d    = ~bus.water_tank_level[0];
    assign pumped_d = (m_q == 2'b01) || (m_q == 2'b10);
    assign trip_d   = (state_q != FAULT) &&
                      (!level_ok_d ||
                       (dry_d && pumped_d && ((state_q == OPEN) || (state_q == RUN))));

    // Sequencing FSM with shared down-timer and latched mode.
    always_ff @(posedge clk) begin
        if (!initialize) begin
            state_q <= IDLE;
            m_q     <= '0;
            timer_q <= '0;
        end else if (trip_d) begin
            state_q <= FAULT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.state != 2'b00) begin
                        m_q     <= bus.state;
                        timer_q <= LEAD_LOAD;
                        state_q <= OPEN;
                    end
                end
                OPEN: begin
                    if (bus.state != m_q) begin
                        m_q     <= '0;
                        state_q <= IDLE;
                    end else if (timer_q == '0) begin
                        timer_q <= RUN_LOAD;
                        state_q <= RUN;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                RUN: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 8'd1;
                    end else if (bus.state != m_q) begin
                        timer_q <= LAG_LOAD;
                        state_q <= STOP;
                    end
                end
                STOP: begin
                    if (timer_q == '0) begin
                        m_q     <= '0;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                    end
                end
                FAULT: begin
                    if ((bus.state == 2'b00) && level_ok_d) begin
                        m_q     <= '0;
                        timer_q <= '0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Actuator drives registered from the registered state and latched mode.
    always_ff @(posedge clk) begin
        if (!initialize) begin
            valve_drip_q      <= 1'b0;
            valve_sprinkler_q <= 1'b0;
            valve_fill_q      <= 1'b0;
            pump_q            <= 1'b0;
            busy_q            <= 1'b0;
            fault_q           <= 1'b0;
        end else begin
            valve_drip_q      <= ((state_q == OPEN) || (state_q == RUN) || (state_q == STOP)) && (m_q == 2'b01);
            valve_sprinkler_q <= ((state_q == OPEN) || (state_q == RUN) || (state_q == STOP)) && (m_q == 2'b10);
            valve_fill_q      <= ((state_q == OPEN) || (state_q == RUN) || (state_q == STOP)) && (m_q == 2'b11);
            pump_q            <= (state_q == RUN) && pumped_d;
            busy_q            <= (state_q != IDLE);
            fault_q           <= (state_q == FAULT);
        end
    end

    assign bus.valve_drip      = valve_drip_q;
    assign bus.valve_sprinkler = valve_sprinkler_q;
    assign bus.valve_fill      = valve_fill_q;
    assign bus.pump            = pump_q;
    assign bus.busy            = busy_q;
    assign bus.fault           = fault_q;

`ifdef IRRIG_CYCLE_COUNT_EN
    logic [7:0] count_q;
    logic       run_done_d;

    // A run counts only when RUN hands over to STOP; a trip out of RUN does not.
    assign run_done_d = (state_q == RUN) && (timer_q == '0) && (bus.state != m_q) &&
                        pumped_d && !trip_d;

    // Saturating count of completed pumped runs.
    always_ff @(posedge clk) begin
        if (!initialize) begin
            count_q <= '0;
        end else if (run_done_d && (count_q != 8'hFF)) begin
            count_q <= count_q + 8'd1;
        end
    end

    assign bus.cycle_count = count_q;
`else
    assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_irrigation_actuator.sv
// Bench for irrigation_actuator: per-scenario tasks push the expected output
// vector for each edge to a scoreboard queue and compare after the edge.
module tb_irrigation_actuator;

    logic clk;
    logic initialize;

    irrigation_actuator_if ifc ();

    irrigation_actuator #(
        .VALVE_LEAD (4),
        .PUMP_LAG   (3),
        .MIN_ON     (10)
    ) dut (
        .clk        (clk),
        .initialize (initialize),
        .bus        (ifc.slave)
    );

    typedef struct packed {
        logic       fault;
        logic       busy;
        logic       pump;
        logic       fill;
        logic       spr;
        logic       drip;
        logic [7:0] cc;
    } obs_t;

`ifdef IRRIG_CYCLE_COUNT_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (errors=%0d checks=%0d)", errors, checks);
        $fatal(1, "watchdog");
    end

    function automatic obs_t sample();
        obs_t o;
        o.fault = ifc.fault;
        o.busy  = ifc.busy;
        o.pump  = ifc.pump;
        o.fill  = ifc.valve_fill;
        o.spr   = ifc.valve_sprinkler;
        o.drip  = ifc.valve_drip;
        o.cc    = ifc.cycle_count;
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        initialize           = 1'b0;
        ifc.state            = 2'b00;
        ifc.water_tank_level = 4'b0011;
        step();
        initialize = 1'b1;
        step();
    endtask

    task automatic test_reset();
        obs_t e, a;
        initialize           = 1'b0;
        ifc.state            = 2'b00;
        ifc.water_tank_level = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            initialize = (k == 0) ? 1'b0 : 1'b1;
            e = '0;
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_drip();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 38; k++) begin
            ifc.state            = (k < 30) ? 2'b01 : 2'b00;
            ifc.water_tank_level = 4'b0011;
            e      = '0;
            e.drip = (k >= 1) && (k <= 33);
            e.pump = (k >= 5) && (k <= 30);
            e.busy = (k >= 1) && (k <= 33);
            e.cc   = (CC_EN && (k >= 30)) ? 8'd1 : 8'd0;
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL drip k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_early_stop();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 20; k++) begin
            ifc.state            = (k < 7) ? 2'b10 : 2'b00;
            ifc.water_tank_level = 4'b0011;
            e      = '0;
            e.spr  = (k >= 1) && (k <= 17);
            e.pump = (k >= 5) && (k <= 14);
            e.busy = (k >= 1) && (k <= 17);
            e.cc   = (CC_EN && (k >= 14)) ? 8'd1 : 8'd0;
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL early_stop k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_dry_run();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            if (k < 12) begin
                ifc.state = 2'b10; ifc.water_tank_level = 4'b0001;
            end else if (k < 20) begin
                ifc.state = 2'b10; ifc.water_tank_level = 4'b0000;
            end else if (k == 20) begin
                ifc.state = 2'b00; ifc.water_tank_level = 4'b0101;
            end else begin
                ifc.state = 2'b00; ifc.water_tank_level = 4'b0001;
            end
            e       = '0;
            e.spr   = (k >= 1) && (k <= 12);
            e.pump  = (k >= 5) && (k <= 12);
            e.fault = (k >= 13) && (k <= 21);
            e.busy  = (k >= 1) && (k <= 21);
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL dry_run k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_invalid_level();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 13; k++) begin
            ifc.state            = (k < 10) ? 2'b11 : 2'b00;
            ifc.water_tank_level = (k == 8) ? 4'b0101 : 4'b0011;
            e       = '0;
            e.fill  = (k >= 1) && (k <= 8);
            e.fault = (k >= 9) && (k <= 10);
            e.busy  = (k >= 1) && (k <= 10);
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL invalid_level k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_refill_empty();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 26; k++) begin
            ifc.state            = (k < 20) ? 2'b11 : 2'b00;
            ifc.water_tank_level = 4'b0000;
            e      = '0;
            e.fill = (k >= 1) && (k <= 23);
            e.busy = (k >= 1) && (k <= 23);
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL refill_empty k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 11; k++) begin
            initialize           = (k == 8) ? 1'b0 : 1'b1;
            ifc.state            = (k <= 8) ? 2'b01 : 2'b00;
            ifc.water_tank_level = 4'b0011;
            e      = '0;
            e.drip = (k >= 1) && (k <= 7);
            e.pump = (k >= 5) && (k <= 7);
            e.busy = (k >= 1) && (k <= 7);
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL reset_mid_run k=%0d got %b want %b", k, a, e);
            end
        end
        initialize = 1'b1;
    endtask

    task automatic test_abort();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 8; k++) begin
            ifc.state            = (k < 2) ? 2'b01 : 2'b00;
            ifc.water_tank_level = 4'b0011;
            e      = '0;
            e.drip = (k >= 1) && (k <= 2);
            e.busy = (k >= 1) && (k <= 2);
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL abort k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, a;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            ifc.state            = (k < 20) ? 2'b01 : 2'b10;
            ifc.water_tank_level = 4'b0011;
            e      = '0;
            e.drip = (k >= 1) && (k <= 23);
            e.spr  = (k >= 25);
            e.pump = ((k >= 5) && (k <= 20)) || (k >= 29);
            e.busy = ((k >= 1) && (k <= 23)) || (k >= 25);
            e.cc   = (CC_EN && (k >= 20)) ? 8'd1 : 8'd0;
            exp_q.push_back(e);
            step();
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b want %b", k, a, e);
            end
        end
    endtask

`ifdef IRRIG_CYCLE_COUNT_EN
    task automatic test_saturation();
        obs_t e, a;
        do_reset();
        for (int r = 0; r < 258; r++) begin
            for (int k = 0; k < 20; k++) begin
                ifc.state            = (k < 14) ? 2'b01 : 2'b00;
                ifc.water_tank_level = 4'b0011;
                step();
            end
            e    = '0;
            e.cc = (r >= 254) ? 8'd255 : 8'(r + 1);
            exp_q.push_back(e);
            a = sample();
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL saturation run=%0d got %b want %b", r, a, e);
            end
        end
    endtask
`endif

    initial begin
        ifc.state            = 2'b00;
        ifc.water_tank_level = 4'b0011;
        initialize           = 1'b0;
        test_reset();
        test_drip();
        test_early_stop();
        test_dry_run();
        test_invalid_level();
        test_refill_empty();
        test_reset_mid_run();
        test_abort();
        test_back_to_back();
`ifdef IRRIG_CYCLE_COUNT_EN
        test_saturation();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigation_actuator.md
# irrigation_actuator

- Downstream stage of the irrigation state register: consumes its 2-bit `state` and drives the physical actuators.
- Actuators driven: drip valve, sprinkler valve, refill valve and pump.
- Enforces safe sequencing: valve opens before the pump starts, pump stops before the valve closes, and a minimum pump run time.
- Trips a latched fault on dry-run or on a corrupt tank-level code.

## Interface
- `VALVE_LEAD`, 4: cycles the valve is open before the pump starts (1..255).
- `PUMP_LAG`, 3: cycles the valve stays open after the pump stops (1..255).
- `MIN_ON`, 10: minimum cycles in RUN before a stop is honoured (1..255).
- `clk` in 1: single clock, all state updates on rising edge.
- `initialize` in 1: reset, synchronous, active-low.
- `state` in 2: requested mode from the state register: 00 idle, 01 drip, 10 sprinkler, 11 refill.
- `water_tank_level` in 4: thermometer-coded tank sensors, bit0 = lowest.
- `valve_drip` out 1: drip valve open.
- `valve_sprinkler` out 1: sprinkler valve open.
- `valve_fill` out 1: refill valve open.
- `pump` out 1: pump motor on.
- `busy` out 1: FSM not in IDLE.
- `fault` out 1: FSM in FAULT.
- `cycle_count` out 8: completed pumped runs (see Configuration).

## Operation
- FSM states: IDLE, OPEN, RUN, STOP, FAULT.
- One 8-bit down-timer is shared across states.
- A 2-bit latched mode `m` is captured on leaving IDLE.
- "Pumped mode" means `m` is 01 or 10. Refill (11) never asserts `pump`.
- Valid level codes: 0000, 0001, 0011, 0111, 1111. Any other code is invalid.
- Dry condition: `water_tank_level[0]==0`.

State transitions:
- IDLE:
  - `state==00` → stay in IDLE.
  - Otherwise → latch `m=state`, load timer `VALVE_LEAD-1`, go to OPEN.
- OPEN:
  - Valve selected by `m` is open; `pump=0`.
  - `state!=m` → IDLE (abort; the pump never ran).
  - Timer==0 → load `MIN_ON-1`, go to RUN.
  - Otherwise → decrement timer.
- RUN:
  - Valve open; `pump=1` if pumped mode.
  - Timer decrements to 0 and holds there.
  - Timer==0 and `state!=m` → load `PUMP_LAG-1`, go to STOP.
- STOP:
  - `pump=0`; valve still open.
  - Timer==0 → IDLE, clear `m`.
  - A new request in STOP is ignored until IDLE is reached, then taken normally.
- FAULT:
  - All valves and pump forced to 0; `fault=1`.
  - Exit to IDLE only when `state==00` and the level code is valid, sampled on the same cycle.

Fault entry, taken from any state except FAULT, with priority over every transition above:
- invalid level code in any state;
- dry condition in OPEN/RUN with a pumped mode.
- Refill mode ignores the dry condition.

Reset and mode-change rules:
- Reset (`initialize==0` at an edge), whether in IDLE or mid-operation:
  - FSM → IDLE, `m=00`, timer=0;
  - all outputs 0, `cycle_count=0`.
- Mode change in RUN before `MIN_ON` expires is deferred until the timer reaches 0.
  - Exception: a fault is never deferred.
- Mode change between two non-idle modes always passes through STOP and IDLE; a direct valve swap never occurs.

## Timing
- All outputs are registered and decoded from the registered FSM state and `m`.
- Request `state=01` sampled at edge N in IDLE:
  - `valve_drip=1` from edge N+1;
  - `pump=1` from edge N+1+`VALVE_LEAD`.
- RUN lasts at least `MIN_ON` cycles.
- Request dropped at edge K with timer already 0:
  - `pump=0` from edge K+1;
  - valve closes at edge K+1+`PUMP_LAG`.
- Fault condition sampled at edge F:
  - `pump=0`, all valves 0 and `fault=1` from edge F+1.
- `busy` follows the registered state: 1 in OPEN/RUN/STOP/FAULT, 0 in IDLE.

## Configuration
- Macro `IRRIG_CYCLE_COUNT_EN`.
- Defined:
  - `cycle_count` increments by 1 on each RUN→STOP transition in a pumped mode;
  - the counter saturates at 255;
  - RUN→FAULT does not count.
- Undefined: `cycle_count` is tied to 0 and no counter register exists.

## Test plan
Default parameters (4/3/10) unless noted.
- Reset mid-RUN: assert `initialize=0` for 1 edge → next cycle all outputs 0, `busy=0`, `cycle_count=0`.
- Drip run:
  - Stimulus: `state=01` at edge 0, level 0011, drop to 00 at edge 30.
  - Required: `valve_drip` 1 from edge 1 to 33; `pump` 1 from edge 5 to 30.
  - With the macro defined: `cycle_count=1`.
- Early stop:
  - Stimulus: `state=10` at edge 0, back to 00 at edge 7.
  - Required: `pump` stays 1 until RUN timer expiry at edge 15; `valve_sprinkler` closes at edge 18.
- Dry-run:
  - Stimulus: sprinkler running, level goes 0001→0000 at edge F.
  - Required: `pump=0`, `fault=1` at F+1.
  - Fault holds while `state=10`; clears one edge after `state=00` with a valid level.
- Invalid level code:
  - Stimulus: level 0101 during refill.
  - Required: FAULT next cycle; `valve_fill=0`.
- Refill with empty tank:
  - Stimulus: `state=11`, level 0000.
  - Required: `valve_fill` opens, `pump` never asserts, no fault.
